// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module     : mips_pkg
// Description: Shared definitions for the multicycle MIPS controller: state
//              encodings, opcode/funct constants, ALU function codes and
//              PC source selects, plus small opcode-class helpers.
// Revision   : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Controller states; codes 6 and 7 are unused and recover to IF.
  typedef enum logic [2:0] {
    S_RST = 3'd0,
    S_IF  = 3'd1,
    S_ID  = 3'd2,
    S_EX  = 3'd3,
    S_MEM = 3'd4,
    S_WB  = 3'd5
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_SLTI  = 6'h0A;
  localparam logic [5:0] c_OP_ANDI  = 6'h0C;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] c_FN_SLL = 6'h00;
  localparam logic [5:0] c_FN_SRL = 6'h02;
  localparam logic [5:0] c_FN_ADD = 6'h20;
  localparam logic [5:0] c_FN_SUB = 6'h22;
  localparam logic [5:0] c_FN_AND = 6'h24;
  localparam logic [5:0] c_FN_OR  = 6'h25;
  localparam logic [5:0] c_FN_XOR = 6'h26;
  localparam logic [5:0] c_FN_NOR = 6'h27;
  localparam logic [5:0] c_FN_SLT = 6'h2A;

  // ALU function codes
  localparam logic [3:0] c_ALU_ADD = 4'd0;
  localparam logic [3:0] c_ALU_SUB = 4'd1;
  localparam logic [3:0] c_ALU_AND = 4'd2;
  localparam logic [3:0] c_ALU_OR  = 4'd3;
  localparam logic [3:0] c_ALU_NOR = 4'd4;
  localparam logic [3:0] c_ALU_XOR = 4'd5;
  localparam logic [3:0] c_ALU_SLT = 4'd6;
  localparam logic [3:0] c_ALU_SLL = 4'd7;
  localparam logic [3:0] c_ALU_SRL = 4'd8;

  // PC source selects
  localparam logic [1:0] c_PCSRC_INC    = 2'd0;
  localparam logic [1:0] c_PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] c_PCSRC_JUMP   = 2'd2;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == c_OP_BEQ) || (op == c_OP_BNE);
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return (op == c_OP_LW) || (op == c_OP_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_alu_dec.sv
`default_nettype none
// ============================================================================
// Module     : mips_alu_dec
// Description: Combinational instruction decoder. Maps (opcode, funct) to the
//              ALU function code and a legal flag covering the supported
//              instruction subset.
// Ports      : opcode [5:0] in  - IR[31:26]
//              funct  [5:0] in  - IR[5:0]
//              alu_op [3:0] out - ALU function code
//              legal        out - 1 when the instruction is supported
// Revision   : 1.0 - initial release
// ============================================================================
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = c_ALU_ADD;
    legal  = 1'b1;
    case (opcode)
      c_OP_RTYPE: begin
        case (funct)
          c_FN_ADD: alu_op = c_ALU_ADD;
          c_FN_SUB: alu_op = c_ALU_SUB;
          c_FN_AND: alu_op = c_ALU_AND;
          c_FN_OR:  alu_op = c_ALU_OR;
          c_FN_NOR: alu_op = c_ALU_NOR;
          c_FN_XOR: alu_op = c_ALU_XOR;
          c_FN_SLT: alu_op = c_ALU_SLT;
          c_FN_SLL: alu_op = c_ALU_SLL;
          c_FN_SRL: alu_op = c_ALU_SRL;
          default:  legal  = 1'b0;
        endcase
      end
      c_OP_ADDI, c_OP_LW, c_OP_SW, c_OP_J: alu_op = c_ALU_ADD;
      c_OP_ANDI:                          alu_op = c_ALU_AND;
      c_OP_ORI:                           alu_op = c_ALU_OR;
      c_OP_SLTI:                          alu_op = c_ALU_SLT;
      // Branches compare by subtraction; the datapath raises zero on equality.
      c_OP_BEQ, c_OP_BNE:                 alu_op = c_ALU_SUB;
      default:                            legal  = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : mips_mc_ctrl
// Description: Multicycle MIPS control unit (RST/IF/ID/EX/MEM/WB) with a
//              retired-instruction counter. Strobes are Moore/Mealy outputs
//              derived combinationally from the registered state.
// Ports      : CLOCK_50 in  - system clock (rising edge)
//              KEY0     in  - asynchronous active-low reset
//              run      in  - permits a new fetch
//              opcode, funct [5:0] in - instruction fields
//              zero     in  - ALU equality flag
//              mem_ready in - memory access completes this cycle
//              state [2:0] out, datapath strobes/selects, pc_source [1:0],
//              alu_op [3:0], illegal pulse, retired [31:0] counter
// Config     : define MIPS_MC_CTRL_MEMWAIT_EN to make IF and MEM wait for
//              mem_ready; otherwise every access completes in one cycle.
// Revision   : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        KEY0,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_b,
  output logic [1:0]  pc_source,
  output logic [3:0]  alu_op,
  output logic        illegal,
  output logic [31:0] retired
);

  state_t      r_state;
  state_t      w_next;
  logic        r_rel;        // set one edge after KEY0 release
  logic [31:0] r_retired;
  logic [3:0]  w_alu_op;
  logic        w_legal;
  logic        w_mem_done;

  mips_alu_dec u_alu_dec (
    .opcode (opcode),
    .funct  (funct),
    .alu_op (w_alu_op),
    .legal  (w_legal)
  );

`ifdef MIPS_MC_CTRL_MEMWAIT_EN
  assign w_mem_done = mem_ready;
`else
  logic w_mem_ready_unused;
  assign w_mem_ready_unused = mem_ready;
  assign w_mem_done         = 1'b1;
`endif

  // Holding RST for one extra edge after release keeps the first fetch
  // from landing on the first edge, whatever the release phase was.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) r_rel <= 1'b0;
    else       r_rel <= 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      r_state   <= S_RST;
      r_retired <= 32'd0;
    end else begin
      r_state <= w_next;
      if ((w_next == S_IF) &&
          ((r_state == S_EX) || (r_state == S_MEM) || (r_state == S_WB)))
        r_retired <= r_retired + 32'd1;
    end
  end

  always_comb begin
    w_next        = r_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_b     = 1'b0;
    pc_source     = c_PCSRC_INC;
    alu_op        = c_ALU_ADD;
    illegal       = 1'b0;
    case (r_state)
      S_RST: begin
        if (run && r_rel) w_next = S_IF;
      end
      S_IF: begin
        // run=0 stalls here with every strobe idle.
        if (run) begin
          mem_read = 1'b1;
          if (w_mem_done) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            w_next   = S_ID;
          end
        end
      end
      S_ID: begin
        if (w_legal) begin
          w_next = S_EX;
        end else begin
          illegal = 1'b1;
          w_next  = S_IF;
        end
      end
      S_EX: begin
        alu_op = w_alu_op;
        if (opcode == c_OP_RTYPE) begin
          w_next = S_WB;
        end else if (is_mem(opcode)) begin
          alu_src_b = 1'b1;
          w_next    = S_MEM;
        end else if (is_branch(opcode)) begin
          // The PC is written only when the branch is taken.
          pc_source     = c_PCSRC_BRANCH;
          pc_write_cond = (opcode == c_OP_BEQ) ? zero : !zero;
          w_next        = S_IF;
        end else if (opcode == c_OP_J) begin
          pc_source = c_PCSRC_JUMP;
          pc_write  = 1'b1;
          w_next    = S_IF;
        end else begin
          alu_src_b = 1'b1;
          w_next    = S_WB;
        end
      end
      S_MEM: begin
        if (opcode == c_OP_LW) begin
          mem_read = 1'b1;
          if (w_mem_done) w_next = S_WB;
        end else if (opcode == c_OP_SW) begin
          mem_write = 1'b1;
          if (w_mem_done) w_next = S_IF;
        end else begin
          w_next = S_IF;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == c_OP_RTYPE);
        mem_to_reg = (opcode == c_OP_LW);
        w_next     = S_IF;
      end
      default: w_next = S_IF;
    endcase
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have port CLOCK_50  input  1  single system clock; all state on its rising edge.
REQ-002 SHALL have port KEY0  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port run  input  1  permits a new fetch when 1.
REQ-004 SHALL have port opcode  input  6  IR[31:26], valid from ID onward.
REQ-005 SHALL have port funct  input  6  IR[5:0], valid from ID onward.
REQ-006 SHALL have port zero  input  1  ALU equality flag, valid in EX.
REQ-007 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-008 SHALL have port state  output  3  current state, drives HEX1 display.
REQ-009 SHALL have ports pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_b  output  1 each  datapath strobes and selects.
REQ-010 SHALL have port pc_source  output  2  0=pc+1, 1=branch target, 2=jump target.
REQ-011 SHALL have port alu_op  output  4  ALU function code.
REQ-012 SHALL have port illegal  output  1  one-cycle pulse on an undecodable instruction.
REQ-013 SHALL have port retired  output  32  retired-instruction counter.

Function
REQ-014 SHALL use state encodings RST=0, IF=1, ID=2, EX=3, MEM=4, WB=5; codes 6 and 7 SHALL return to IF.
REQ-015 RST SHALL go to IF when run=1; otherwise it SHALL stay in RST.
REQ-016 IF SHALL assert mem_read; in the completing cycle it SHALL also assert ir_write and pc_write with pc_source=0, then go to ID.
REQ-017 ID SHALL decode add, sub, and, or, nor, xor, slt, sll, srl, addi, lw, sw, andi, ori, slti, beq, bne and j.
REQ-018 ID SHALL go to EX for a legal instruction; for an illegal one it SHALL pulse illegal, issue no strobes and go to IF.
REQ-019 EX for an R-type instruction SHALL output alu_op from funct with alu_src_b=0, then go to WB.
REQ-020 EX for an I-type ALU instruction or lw/sw SHALL assert alu_src_b=1; lw and sw go to MEM, the others to WB.
REQ-021 EX for beq/bne SHALL assert pc_write_cond with pc_source=1 and write the PC only when zero (beq) or !zero (bne) is true, then go to IF.
REQ-022 EX for j SHALL assert pc_write with pc_source=2, then go to IF.
REQ-023 MEM SHALL assert mem_read for lw or mem_write for sw; on completion lw goes to WB and sw goes to IF.
REQ-024 WB SHALL assert reg_write for one cycle, with reg_dst=1 for R-type and mem_to_reg=1 for lw, then go to IF.
REQ-025 retired SHALL increment by 1 on every transition into IF from EX, MEM or WB, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 Any state except RST SHALL go to IF when its work is complete, even if run=0; with run=0 the block SHALL stall in IF with no strobes, and run is checked before each fetch.
REQ-027 Strobes SHALL be combinational from the registered state and the inputs; no strobe SHALL be asserted outside its listed state.
REQ-028 Cycles per instruction with zero-wait memory SHALL be: R-type/I-ALU 4, lw 5, sw 4, beq/bne/j 3.

Reset
REQ-029 KEY0=0 SHALL immediately force state=RST, retired=0, all strobes 0 and illegal=0, including in the middle of an instruction.
REQ-030 After KEY0 is released, the first IF SHALL occur no earlier than the second rising edge.

Configuration
REQ-031 With MIPS_MC_CTRL_MEMWAIT_EN defined, IF and MEM SHALL hold, keeping mem_read/mem_write asserted, until mem_ready=1.
REQ-032 In that wait, ir_write, pc_write and the state transition SHALL occur only in the mem_ready=1 cycle.
REQ-033 Without MIPS_MC_CTRL_MEMWAIT_EN, mem_ready SHALL be ignored and every memory access SHALL complete in one cycle.

Structure
REQ-034 Package mips_pkg SHALL hold the state encodings, opcode and funct constants, alu_op codes and pc_source codes.
REQ-035 Sub-module mips_alu_dec SHALL map (opcode, funct) to {alu_op, legal} combinationally.

Verification
REQ-036 Release KEY0 with run=1, then execute add (funct 0x20): required state sequence 0,1,2,3,5,1; reg_write for exactly 1 cycle; retired=1.
REQ-037 lw (0x23) with MEMWAIT_EN and mem_ready=0 for 3 cycles in MEM: the block holds in MEM with mem_read=1 for 4 cycles, then WB with mem_to_reg=1.
REQ-038 beq (0x04) with zero=1: pc_write_cond=1 and pc_source=1 in EX; bne (0x05) with zero=1: no PC write; each takes 3 cycles.
REQ-039 opcode 0x3F: illegal pulses for 1 cycle in ID, no strobes, next state IF, retired unchanged.
REQ-040 KEY0 asserted during MEM of sw (0x2B): mem_write drops the same cycle, state=0, retired=0.
REQ-041 Preload retired=0xFFFFFFFF by forcing, then retire j (0x02): retired=0.
